// File: rtl/ysyx_23060286_pkg.sv
// Shared types and constants for the ysyx_23060286 multi-cycle sequencer.
// The sequencer FSM states, halt reasons and the reset instruction live here.
package ysyx_23060286_pkg;

  typedef enum logic [2:0] {
    FETCH,
    IWAIT,
    EXEC,
    MEM,
    MWAIT,
    WB,
    HALT
  } state_t;

  localparam logic [1:0] HALT_NONE   = 2'd0;
  localparam logic [1:0] HALT_EBREAK = 2'd1;
  localparam logic [1:0] HALT_IFU_TO = 2'd2;
  localparam logic [1:0] HALT_LSU_TO = 2'd3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060286_wdog.sv
// Bus watchdog: counts cycles spent waiting for a response and flags the
// cycle in which the wait would reach TIMEOUT cycles.
module ysyx_23060286_wdog
  import ysyx_23060286_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // The count holds the wait cycles already completed, so the current
  // waiting cycle is the last allowed one when the count equals TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/ysyx_23060286_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: walks the single-cycle datapath
// through fetch, execute, memory and writeback, and commits via pc_we/gpr_we.
module ysyx_23060286_seq_ctrl
  import ysyx_23060286_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_wen,
  input  logic        dec_ebreak,
  output logic        lsu_req,
  output logic        lsu_we,
  input  logic        lsu_gnt,
  input  logic        lsu_rvalid,
  output logic        pc_we,
  output logic        gpr_we,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  halt_code
);

  state_t     state;
  state_t     state_next;
  logic [1:0] code_next;
  logic       inst_latch;
  logic       wd_clear;
  logic       wd_en;
  logic       wd_expired;

  ysyx_23060286_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // A response arriving in the same cycle as the watchdog expiry still wins.
  always_comb begin
    state_next = state;
    code_next  = HALT_NONE;
    case (state)
      FETCH: begin
        if (ifu_ready && ifu_rvalid) begin
          state_next = EXEC;
        end else if (ifu_ready) begin
          state_next = IWAIT;
        end
      end
      IWAIT: begin
        if (ifu_rvalid) begin
          state_next = EXEC;
        end else if (wd_expired) begin
          state_next = HALT;
          code_next  = HALT_IFU_TO;
        end
      end
      EXEC: begin
        if (dec_ebreak) begin
          state_next = HALT;
          code_next  = HALT_EBREAK;
        end else if (dec_load || dec_store) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        if (lsu_gnt && lsu_rvalid) begin
          state_next = WB;
        end else if (lsu_gnt) begin
          state_next = MWAIT;
        end
      end
      MWAIT: begin
        if (lsu_rvalid) begin
          state_next = WB;
        end else if (wd_expired) begin
          state_next = HALT;
          code_next  = HALT_LSU_TO;
        end
      end
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  assign inst_latch = ((state == FETCH) && ifu_ready && ifu_rvalid) ||
                      ((state == IWAIT) && ifu_rvalid);

  assign wd_clear = ((state_next == IWAIT) && (state != IWAIT)) ||
                    ((state_next == MWAIT) && (state != MWAIT));
  assign wd_en    = (state == IWAIT) || (state == MWAIT);

  // inst stays put until the next fetch so decode is stable through WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst      <= NOP_INST;
      instret   <= '0;
      halt_code <= HALT_NONE;
    end else begin
      if (inst_latch) begin
        inst <= ifu_rdata;
      end
      if (state == WB) begin
        instret <= instret + 32'd1;
      end
      if ((state_next == HALT) && (state != HALT)) begin
        halt_code <= code_next;
      end
    end
  end

  assign ifu_req = (state == FETCH);
  assign lsu_req = (state == MEM);
  assign lsu_we  = (state == MEM) && dec_store;
  assign pc_we   = (state == WB);
  assign gpr_we  = (state == WB) && dec_wen && !dec_store;
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_ysyx_23060286_seq_ctrl.sv
// Scoreboard bench for the sequencer: a bus driver plays randomized fetch and
// LSU latencies while a monitor checks each retire/halt against a timing model.
module tb_ysyx_23060286_seq_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [31:0] inst;
  logic        dec_load, dec_store, dec_wen, dec_ebreak;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic        pc_we, gpr_we, halted;
  logic [31:0] instret;
  logic [1:0]  halt_code;

  typedef struct {
    bit          is_halt;
    int          cyc;
    logic [31:0] inst;
    logic        gpr_we;
    logic        mem;
    logic        lsu_we;
    logic [31:0] instret;
    logic [1:0]  code;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   tcyc = 0;
  int   m_next;
  int   m_count;
  bit   m_halted;

  ysyx_23060286_seq_ctrl #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifu_req   (ifu_req),
    .ifu_ready (ifu_ready),
    .ifu_rvalid(ifu_rvalid),
    .ifu_rdata (ifu_rdata),
    .inst      (inst),
    .dec_load  (dec_load),
    .dec_store (dec_store),
    .dec_wen   (dec_wen),
    .dec_ebreak(dec_ebreak),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_gnt   (lsu_gnt),
    .lsu_rvalid(lsu_rvalid),
    .pc_we     (pc_we),
    .gpr_we    (gpr_we),
    .instret   (instret),
    .halted    (halted),
    .halt_code (halt_code)
  );

  // Stand-in for the IDU, decoding only what the sequencer consumes.
  assign dec_load   = (inst[6:0] == 7'b0000011);
  assign dec_store  = (inst[6:0] == 7'b0100011);
  assign dec_ebreak = (inst == 32'h0010_0073);
  assign dec_wen    = dec_load || (inst[6:0] == 7'b0010011) ||
                      (inst[6:0] == 7'b0110011) || (inst[6:0] == 7'b0110111);

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got no end, expected $finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 ebreak
  function automatic logic [31:0] makeInst(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      1:       return {r[31:20], r[19:15], 3'b010, r[11:7], 7'b0000011};
      2:       return {r[31:25], r[24:20], r[19:15], 3'b010, r[11:7], 7'b0100011};
      3:       return 32'h0010_0073;
      default: return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
    endcase
  endfunction

  task automatic applyStimulus(input logic [31:0] w, input int d1, input int d2,
                               input bit mem, input int g, input int r);
    for (int i = 0; i < 40 && !ifu_req; i++) @(negedge clk);
    checkOutput("fetch_req", 32'(ifu_req), 32'd1);
    if (!ifu_req) return;
    for (int k = 0; k < d1; k++) begin
      ifu_rvalid = 1'($urandom_range(0, 1));
      ifu_rdata  = $urandom;
      @(negedge clk);
    end
    ifu_ready = 1'b1; ifu_rvalid = (d2 == 0); ifu_rdata = w;
    @(negedge clk);
    ifu_ready = 1'b0; ifu_rvalid = 1'b0;
    for (int k = 1; k <= d2; k++) begin
      ifu_rvalid = (k == d2);
      @(negedge clk);
      ifu_rvalid = 1'b0;
    end
    ifu_rdata = $urandom;
    if (!mem) return;
    for (int i = 0; i < 40 && !lsu_req; i++) @(negedge clk);
    checkOutput("mem_req", 32'(lsu_req), 32'd1);
    if (!lsu_req) return;
    for (int k = 0; k < g; k++) begin
      lsu_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    lsu_gnt = 1'b1; lsu_rvalid = (r == 0);
    @(negedge clk);
    lsu_gnt = 1'b0; lsu_rvalid = 1'b0;
    for (int k = 1; k <= r; k++) begin
      lsu_rvalid = (k == r);
      @(negedge clk);
      lsu_rvalid = 1'b0;
    end
  endtask

  // Model: a plain instruction takes 3 cycles, +1 for memory, +1 per wait
  // cycle on either port; a wait longer than T cycles halts instead.
  task automatic runInst(input int kind, input int d1, input int d2, input int g, input int r);
    exp_t e;
    bit mem;
    int s;
    logic [31:0] w;
    w   = makeInst(kind);
    mem = (kind == 1) || (kind == 2);
    s   = m_next;
    e   = '{is_halt: 0, cyc: 0, inst: w, gpr_we: 0, mem: 0, lsu_we: 0,
            instret: 32'(m_count), code: 2'd0};
    if (kind == 3) begin
      e.is_halt = 1; e.code = 2'd1; e.cyc = s + d1 + d2 + 2;
    end else if (d2 > T) begin
      e.is_halt = 1; e.code = 2'd2; e.cyc = s + d1 + T + 1;
    end else if (mem && r > T) begin
      e.is_halt = 1; e.code = 2'd3; e.cyc = s + d1 + d2 + g + T + 3;
    end else begin
      e.cyc    = mem ? s + 3 + d1 + d2 + g + r : s + 2 + d1 + d2;
      e.gpr_we = (kind != 2);
      e.mem    = mem;
      e.lsu_we = (kind == 2);
      m_count++;
      m_next = e.cyc + 1;
    end
    m_halted = e.is_halt;
    expq.push_back(e);
    applyStimulus(w, d1, d2, mem && (d2 <= T), g, r);
  endtask

  task automatic startSegment();
    ifu_ready = 0; ifu_rvalid = 0; ifu_rdata = '0; lsu_gnt = 0; lsu_rvalid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_next = tcyc; m_count = 0; m_halted = 0;
    checkOutput("rst_ifu_req", 32'(ifu_req), 32'd1);
    checkOutput("rst_lsu_req", 32'(lsu_req), 32'd0);
    checkOutput("rst_commit", 32'({pc_we, gpr_we}), 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_halt_code", 32'(halt_code), 32'd0);
    checkOutput("rst_inst", inst, 32'h0000_0013);
  endtask

  task automatic finishSegment();
    if (m_halted) begin
      repeat (20) @(negedge clk);
      checkOutput("halt_sticky", 32'(halted), 32'd1);
    end
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge clk);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  // Monitor: pops one expectation per retire or halt entry.
  initial begin
    bit   prev_halt;
    logic seen_we;
    exp_t e;
    prev_halt = 0;
    seen_we   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_halt = 0;
      end else begin
        if (lsu_req) begin
          seen_we = lsu_we;
          checkOutput("req_exclusive", 32'(ifu_req), 32'd0);
        end
        if (halted) begin
          if (!prev_halt) begin
            if (expq.size() == 0) begin
              checkOutput("unexpected_halt", 32'(halted), 32'd0);
            end else begin
              e = expq.pop_front();
              checkOutput("event_is_halt", 32'(e.is_halt), 32'd1);
              checkOutput("halt_cycle", 32'(tcyc), 32'(e.cyc));
              checkOutput("halt_code", 32'(halt_code), 32'(e.code));
              checkOutput("halt_instret", instret, e.instret);
            end
          end
          checkOutput("halt_quiet", 32'({ifu_req, lsu_req, pc_we, gpr_we}), 32'd0);
        end else if (pc_we) begin
          if (expq.size() == 0) begin
            checkOutput("unexpected_retire", 32'(pc_we), 32'd0);
          end else begin
            e = expq.pop_front();
            checkOutput("event_is_retire", 32'(e.is_halt), 32'd0);
            checkOutput("retire_cycle", 32'(tcyc), 32'(e.cyc));
            checkOutput("retire_inst", inst, e.inst);
            checkOutput("retire_gpr_we", 32'(gpr_we), 32'(e.gpr_we));
            checkOutput("retire_instret", instret, e.instret);
            if (e.mem) checkOutput("lsu_we", 32'(seen_we), 32'(e.lsu_we));
          end
        end else if (gpr_we) begin
          checkOutput("gpr_we_without_pc_we", 32'(gpr_we), 32'd0);
        end
        prev_halt = halted;
      end
    end
  end

  initial begin
    int n, ending, kind;
    rst = 1'b1;
    ifu_ready = 0; ifu_rvalid = 0; ifu_rdata = '0; lsu_gnt = 0; lsu_rvalid = 0;

    $display("[TB] zero-wait addi stream");
    startSegment();
    repeat (4) runInst(0, 0, 0, 0, 0);
    finishSegment();

    $display("[TB] delayed fetch handshake");
    startSegment();
    runInst(0, 2, 3, 0, 0);
    runInst(0, 0, 0, 0, 0);
    finishSegment();

    $display("[TB] load with wait states, then store");
    startSegment();
    runInst(1, 0, 0, 1, 4);
    runInst(2, 0, 1, 0, 1);
    runInst(2, 1, 0, 2, T);
    finishSegment();

    $display("[TB] ebreak after two instructions");
    startSegment();
    runInst(0, 0, 0, 0, 0);
    runInst(1, 0, 0, 0, 0);
    runInst(3, 0, 0, 0, 0);
    finishSegment();

    $display("[TB] LSU and fetch timeouts");
    startSegment();
    runInst(1, 0, 0, 1, T + 1);
    finishSegment();
    startSegment();
    runInst(0, 1, T + 1, 0, 0);
    finishSegment();

    $display("[TB] reset during MWAIT");
    startSegment();
    applyStimulus(makeInst(1), 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && !lsu_req; i++) @(negedge clk);
    lsu_gnt = 1'b1;
    @(negedge clk);
    lsu_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lsu_rvalid = 1'b1;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    checkOutput("midrst_ifu_req", 32'(ifu_req), 32'd1);
    checkOutput("midrst_instret", instret, 32'd0);
    checkOutput("midrst_commit", 32'({pc_we, gpr_we, lsu_req}), 32'd0);
    @(negedge clk);
    checkOutput("midrst_late_rvalid", 32'({ifu_req, pc_we, gpr_we}), 32'b100);
    checkOutput("midrst_instret2", instret, 32'd0);
    finishSegment();

    $display("[TB] randomized segments");
    for (int seg = 0; seg < 30; seg++) begin
      startSegment();
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        ending = (j == n - 1) ? $urandom_range(0, 7) : 7;
        if (ending <= 1) begin
          runInst(3, $urandom_range(0, 3), $urandom_range(0, T), 0, 0);
        end else if (ending == 2) begin
          runInst(0, $urandom_range(0, 3), T + 1, 0, 0);
        end else if (ending == 3) begin
          runInst($urandom_range(1, 2), $urandom_range(0, 3), $urandom_range(0, T),
                  $urandom_range(0, 2), T + 1);
        end else begin
          kind = $urandom_range(0, 2);
          runInst(kind, $urandom_range(0, 3), $urandom_range(0, T),
                  $urandom_range(0, 2), $urandom_range(0, T));
        end
      end
      finishSegment();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060286_seq_ctrl.md
# ysyx_23060286_seq_ctrl

Multi-cycle sequencer for the NPC core. Takes the single-cycle datapath (PC, GPR file, IDU, ALU, IMM) and drives it through fetch, execute, memory and writeback phases. It handshakes with an instruction-fetch port and a load/store port that may have wait states. Architectural state changes happen only through the `pc_we` and `gpr_we` commit pulses; it also counts retired instructions and halts on `ebreak` or bus timeout.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles to wait for `ifu_rvalid`/`lsu_rvalid` after a request is accepted.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_req` out 1: fetch request for the current PC.
- `ifu_ready` in 1: fetch request accepted this cycle.
- `ifu_rvalid` in 1: fetch data valid.
- `ifu_rdata` in 32: fetched instruction.
- `inst` out 32: latched instruction, fed to IDU/IMM/GPR address fields.
- `dec_load` in 1: decoded load (from IDU, combinational on `inst`).
- `dec_store` in 1: decoded store.
- `dec_wen` in 1: decoded register write enable.
- `dec_ebreak` in 1: decoded `ebreak`.
- `lsu_req` out 1: data access request.
- `lsu_we` out 1: store (1) or load (0); valid with `lsu_req`.
- `lsu_gnt` in 1: data request accepted.
- `lsu_rvalid` in 1: load data valid, or store completion.
- `pc_we` out 1: one-cycle PC update strobe (PC loads `npc`).
- `gpr_we` out 1: one-cycle register write strobe.
- `instret` out 32: retired-instruction counter; wraps modulo 2^32.
- `halted` out 1: sticky halt flag.
- `halt_code` out 2: 0 none, 1 `ebreak`, 2 fetch timeout, 3 LSU timeout.

## Operation
- States: `FETCH`, `IWAIT`, `EXEC`, `MEM`, `MWAIT`, `WB`, `HALT`.
- `FETCH`: `ifu_req`=1.
  - `ifu_ready` and `ifu_rvalid` both high: latch `inst`, go to `EXEC`.
  - `ifu_ready` only: go to `IWAIT`.
  - Otherwise stay in `FETCH`.
  - `ifu_rvalid` without `ifu_ready` is ignored.
- `IWAIT`: on `ifu_rvalid`, latch `inst` and go to `EXEC`. On timeout, go to `HALT` with code 2.
- `EXEC`: decode outputs are valid here. Priority:
  1. `dec_ebreak` → `HALT`, code 1, no commit.
  2. `dec_load` or `dec_store` → `MEM`.
  3. Otherwise → `WB`.
- `MEM`: `lsu_req`=1, `lsu_we`=`dec_store`.
  - `lsu_gnt` and `lsu_rvalid` together → `WB`.
  - `lsu_gnt` only → `MWAIT`.
- `MWAIT`: on `lsu_rvalid` → `WB`. On timeout → `HALT` with code 3.
- `WB`: `pc_we`=1, `gpr_we`=`dec_wen` and not `dec_store`, `instret`+1, then → `FETCH`.
- `HALT`: absorbing until `rst`. All request and commit outputs are 0; `halted`=1.
- `inst` holds its value from latch until the next latch. IDU outputs must stay stable through `WB`.
- Watchdog counter:
  - Clears on entry to `IWAIT`/`MWAIT`.
  - Increments each cycle spent waiting.
  - Timeout fires when the count reaches `TIMEOUT` with no `rvalid` that cycle. An `rvalid` arriving in the same cycle wins.

## Timing
- Reset values: state `FETCH`; `inst`=32'h0000_0013 (nop); `instret`=0; `halted`=0; `halt_code`=0. `ifu_req` is 1 in the first cycle after reset; all other strobes are 0.
- Reset mid-operation: `rst` overrides all transitions. Responses already in flight are dropped, with no commit and no counter change.
- Zero-wait non-memory instruction: 3 cycles (`FETCH`, `EXEC`, `WB`).
- Zero-wait load/store: 4 cycles.
- Each wait cycle on either port adds exactly 1 cycle.
- `pc_we`/`gpr_we` are asserted for exactly one cycle per retired instruction and never in `HALT`.
- `ifu_req`/`lsu_req` are held high until accepted and are never asserted together.
- All outputs are registered or decoded from state only; there are no combinational paths from bus inputs to request outputs.

## Structure
- Shared package `ysyx_23060286_pkg` holds:
  - the state enum;
  - the halt-code constants (`HALT_NONE`, `HALT_EBREAK`, `HALT_IFU_TO`, `HALT_LSU_TO`);
  - the nop encoding.
- One sub-module, `ysyx_23060286_wdog`: a `$clog2(TIMEOUT+1)`-bit counter with clear, enable and `expired` outputs.
- The top-level core instantiates this block next to PC/GPR. PC's write enable and GPR's `wen` are gated by `pc_we`/`gpr_we`.

## Test plan
- Zero-wait `addi` stream (`ifu_ready`=`ifu_rvalid`=1): `pc_we` pulses every 3rd cycle; `instret`=4 after 12 cycles; `gpr_we` coincides with `pc_we`.
- Fetch with `ifu_ready` delayed 2 cycles and `rvalid` 3 cycles later: `inst` is latched on the `rvalid` cycle; retire happens 5 cycles later than the zero-wait case.
- Load with `lsu_gnt` in cycle 1 and `lsu_rvalid` 4 cycles later: `gpr_we`=1 in `WB`. Store: `lsu_we`=1 and `gpr_we`=0.
- `ebreak` (0x00100073) after 2 instructions: `halted`=1, `halt_code`=1, `instret`=2, and no further requests for 20 cycles.
- `TIMEOUT`=4 with `lsu_rvalid` never asserted: `HALT` with `halt_code`=3. Repeat with `rvalid` exactly on the 4th wait cycle: retires normally.
- `rst` asserted during `MWAIT`: the next cycle shows `FETCH`, `ifu_req`=1, `instret`=0; a late `lsu_rvalid` has no effect.
